// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : holds the architectural PC, fetches instr at PC, checks npc
// Revision 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        addr_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Last legal word address, widened to 33 bits so the bound cannot wrap.
  localparam logic [32:0] IM_LAST = {1'b0, IM_BASE} + {IM_WORDS[30:0], 2'b00} - 33'd4;

  state_t r_state;
  state_t w_next_state;
  logic   w_npc_legal;
  logic   w_accept;
  logic   w_capture;

  assign w_npc_legal = (npc[1:0] == 2'b00) && (npc >= IM_BASE) && ({1'b0, npc} <= IM_LAST);
  assign w_accept    = (r_state == VALID) && advance;
  assign w_capture   = (r_state == FETCH) && imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= BOOT;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        instr <= imem_rdata;
      end
      if (w_accept) begin
        pc          <= npc;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    addr_err     = 1'b0;
    imem_addr    = pc;
    case (r_state)
      BOOT: begin
        w_next_state = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          w_next_state = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (advance) begin
          w_next_state = w_npc_legal ? FETCH : ERROR;
        end
      end
      ERROR: begin
        addr_err = 1'b1;
      end
      default: begin
        w_next_state = BOOT;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_unit : directed + randomized bench with an address-level model
// Revision 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural PC and advance count.
  logic [31:0] m_pc;
  logic [31:0] m_count;

  pc_fetch_unit #(
    .RESET_PC (RESET_PC),
    .IM_BASE  (IM_BASE),
    .IM_WORDS (IM_WORDS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .npc         (npc),
    .advance     (advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .addr_err    (addr_err),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit npc_legal(input logic [31:0] v);
    longint unsigned lo = longint'(IM_BASE);
    longint unsigned hi = longint'(IM_BASE) + 4 * longint'(IM_WORDS) - 4;
    longint unsigned a  = longint'(v);
    return (a % 4 == 0) && (a >= lo) && (a <= hi);
  endfunction

  // Drives reset (optionally with a same-cycle ready/rdata) and walks to FETCH.
  task automatic do_reset(input logic [31:0] rdata);
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = rdata;
    advance    = 1'b0;
    step();
    check("rst_instr", instr, 32'd0);
    check("rst_valid", instr_valid, 1'b0);
    step();
    reset      = 1'b0;
    imem_ready = 1'b0;
    m_pc       = RESET_PC;
    m_count    = 32'd0;
    check("rst_pc", pc, RESET_PC);
    check("rst_req", imem_req, 1'b0);
    check("rst_err", addr_err, 1'b0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_instr2", instr, 32'd0);
    step();
    check("boot_req", imem_req, 1'b1);
    check("boot_addr", imem_addr, 32'h0000_3000);
  endtask

  // In FETCH: stall for 'waits' cycles (with ignored advance pulses), then return data.
  task automatic do_fetch(input int waits, input logic [31:0] data);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      advance    = $urandom_range(0, 1) == 1;
      npc        = 32'h0000_3100;
      check("wait_req", imem_req, 1'b1);
      check("wait_addr", imem_addr, m_pc);
      check("wait_valid", instr_valid, 1'b0);
      step();
    end
    advance    = 1'b1;
    npc        = 32'h0000_3100;
    imem_ready = 1'b1;
    imem_rdata = data;
    check("rdy_addr", imem_addr, m_pc);
    step();
    advance    = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("got_valid", instr_valid, 1'b1);
    check("got_instr", instr, data);
    check("got_pc", pc, m_pc);
    check("got_count", fetch_count, m_count);
    check("got_req", imem_req, 1'b0);
  endtask

  // In VALID: idle a little, then advance to v and check legal/illegal outcome.
  task automatic do_advance(input logic [31:0] v);
    int idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      step();
      check("idle_valid", instr_valid, 1'b1);
    end
    advance = 1'b1;
    npc     = v;
    step();
    advance = 1'b0;
    m_pc    = v;
    m_count = m_count + 32'd1;
    check("adv_pc", pc, m_pc);
    check("adv_count", fetch_count, m_count);
    check("adv_valid", instr_valid, 1'b0);
    if (npc_legal(v)) begin
      check("adv_req", imem_req, 1'b1);
      check("adv_addr", imem_addr, v);
      check("adv_err", addr_err, 1'b0);
    end else begin
      check("err_flag", addr_err, 1'b1);
      check("err_req", imem_req, 1'b0);
      for (int i = 0; i < 3; i++) begin
        advance    = 1'b1;
        npc        = 32'h0000_3004;
        imem_ready = 1'b1;
        step();
        check("err_hold_req", imem_req, 1'b0);
        check("err_hold_pc", pc, m_pc);
        check("err_hold_cnt", fetch_count, m_count);
        check("err_hold_flag", addr_err, 1'b1);
      end
      advance    = 1'b0;
      imem_ready = 1'b0;
    end
  endtask

  initial begin
    reset      = 1'b1;
    npc        = 32'd0;
    advance    = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'd0;
    m_pc       = RESET_PC;
    m_count    = 32'd0;

    // reset with ready high, then boot
    do_reset($urandom);

    // fetch latency with three wait cycles
    do_fetch(3, 32'h3C01_1234);

    // sequential / branch / backward
    do_advance(32'h0000_3004);
    do_fetch($urandom_range(0, 3), $urandom);
    do_advance(32'h0000_3010);
    do_fetch($urandom_range(0, 3), $urandom);
    do_advance(32'h0000_3004);
    do_fetch(0, $urandom);
    check("t3_count", fetch_count, 32'd3);

    // refetch of the same address
    do_advance(m_pc);
    do_fetch(1, $urandom);

    // last word is legal
    do_advance(IM_BASE + 4 * IM_WORDS - 4);
    do_fetch($urandom_range(0, 2), $urandom);

    // random legal addresses
    for (int k = 0; k < 10; k++) begin
      do_advance(IM_BASE + 4 * $urandom_range(0, IM_WORDS - 1));
      do_fetch($urandom_range(0, 4), $urandom);
    end

    // illegal npc cases, each recovered by reset
    do_advance(32'h0000_3002);
    do_reset($urandom);
    do_fetch(0, $urandom);
    do_advance(IM_BASE + 4 * IM_WORDS);
    do_reset($urandom);
    do_fetch(2, $urandom);
    do_advance(32'h0000_2FFC);
    do_reset($urandom);

    // reset coinciding with ready: data must be dropped
    do_fetch(1, $urandom);
    do_advance(32'h0000_3040);
    do_reset(32'hDEAD_BEEF);
    check("t6_instr", instr, 32'd0);
    check("t6_valid", instr_valid, 1'b0);
    do_fetch(0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
